// File: rtl/dsg_wave_source_if.sv
// Select-change request channel into the wave source: valid/ready handshake carrying
// the requested 2-bit mux select.
interface dsg_wave_source_if;
    logic       cfg_valid;
    logic [1:0] cfg_sel;
    logic       cfg_ready;

    modport master (output cfg_valid, output cfg_sel, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_sel, output cfg_ready);
endinterface

// File: rtl/dsg_wave_source.sv
// Four 1-bit waveforms from one shared period counter, plus a mux select that only
// changes on a period boundary so the muxed output never carries a truncated period.
module dsg_wave_source #(
    parameter int          CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty,
    dsg_wave_source_if.slave cfg,
    output logic             wave_sq,
    output logic             wave_pwm,
    output logic             wave_pulse,
    output logic             wave_prn,
    output logic [1:0]       sel,
    output logic             sel_switched
);
    typedef enum logic {S_IDLE, S_PEND} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_l_q, period_l_d;
    logic [CNT_W-1:0] duty_l_q, duty_l_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [3:0]       wave_q, wave_d;   // {sq, pwm, pulse, prn}
    logic [1:0]       pend_sel_q, pend_sel_d;
    logic [1:0]       sel_q, sel_d;
    logic             sel_sw_q, sel_sw_d;

    logic [CNT_W-1:0] period_eff;
    logic             wrap;
    logic             lfsr_fb;

    // Periods of 0 or 1 cannot hold both a high and a low phase, so clamp to 2.
    assign period_eff = (period < CNT_W'(2)) ? CNT_W'(2) : period;
    assign wrap       = en && (cnt_q == period_l_q - CNT_W'(1));
    assign lfsr_fb    = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    always_comb begin
        cnt_d      = cnt_q;
        period_l_d = period_l_q;
        duty_l_d   = duty_l_q;
        lfsr_d     = lfsr_q;
        wave_d     = '0;
        if (!en) begin
            cnt_d      = '0;
            period_l_d = period_eff;
            duty_l_d   = duty;
        end else begin
            wave_d = {cnt_q < (period_l_q >> 1), cnt_q < duty_l_q,
                      cnt_q == '0, lfsr_q[0]};
            if (wrap) begin
                cnt_d      = '0;
                period_l_d = period_eff;
                duty_l_d   = duty;
                lfsr_d     = {lfsr_fb, lfsr_q[15:1]};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Select FSM: one request in flight; it lands on the wrap edge, or at once when idle.
    always_comb begin
        state_d       = state_q;
        pend_sel_d    = pend_sel_q;
        sel_d         = sel_q;
        sel_sw_d      = 1'b0;
        cfg.cfg_ready = (state_q == S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (cfg.cfg_valid) begin
                    pend_sel_d = cfg.cfg_sel;
                    state_d    = S_PEND;
                end
            end
            S_PEND: begin
                if (!en || wrap) begin
                    sel_d    = pend_sel_q;
                    sel_sw_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            period_l_q <= CNT_W'(2);
            duty_l_q   <= '0;
            lfsr_q     <= LFSR_SEED;
            wave_q     <= '0;
            pend_sel_q <= '0;
            sel_q      <= '0;
            sel_sw_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_l_q <= period_l_d;
            duty_l_q   <= duty_l_d;
            lfsr_q     <= lfsr_d;
            wave_q     <= wave_d;
            pend_sel_q <= pend_sel_d;
            sel_q      <= sel_d;
            sel_sw_q   <= sel_sw_d;
        end
    end

    assign {wave_sq, wave_pwm, wave_pulse, wave_prn} = wave_q;
    assign sel          = sel_q;
    assign sel_switched = sel_sw_q;
endmodule

// File: tb/tb_dsg_wave_source.sv
// Scoreboard bench for dsg_wave_source: stimulus pushes per-cycle expectations and
// select-switch events; a negedge monitor pops and compares them.
module tb_dsg_wave_source;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] period;
    logic [15:0] duty;
    logic        wave_sq, wave_pwm, wave_pulse, wave_prn;
    logic [1:0]  sel;
    logic        sel_switched;

    dsg_wave_source_if cfg_if();

    dsg_wave_source #(.CNT_W(16), .LFSR_SEED(16'hACE1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .period       (period),
        .duty         (duty),
        .cfg          (cfg_if.slave),
        .wave_sq      (wave_sq),
        .wave_pwm     (wave_pwm),
        .wave_pulse   (wave_pulse),
        .wave_prn     (wave_prn),
        .sel          (sel),
        .sel_switched (sel_switched)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] w;     // {sq, pwm, pulse, prn}
        logic [3:0] m;
        logic       rdy;
        logic [1:0] sel;
        string      nm;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [1:0] sel;
    } sw_t;

    exp_t wq[$];
    sw_t  swq[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Expectations for cycles c0..c1; pattern bit i is the value at period position i.
    task automatic run(input string nm, input int base, input int c0, input int c1,
                       input int per, input logic [15:0] sqp, input logic [15:0] pwp,
                       input logic [15:0] plp, input logic prn, input logic chk_prn,
                       input logic rdy, input logic [1:0] s);
        for (int c = c0; c <= c1; c++) begin
            int   i;
            exp_t e;
            i     = (c - base) % per;
            e.cyc = c;
            e.w   = {sqp[i], pwp[i], plp[i], prn};
            e.m   = {3'b111, chk_prn};
            e.rdy = rdy;
            e.sel = s;
            e.nm  = nm;
            wq.push_back(e);
        end
    endtask

    task automatic push_sw(input int c, input logic [1:0] s);
        sw_t x;
        x.cyc = c;
        x.sel = s;
        swq.push_back(x);
    endtask

    task automatic step_to(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [3:0] act;
        act = {wave_sq, wave_pwm, wave_pulse, wave_prn};
        while (wq.size() > 0 && wq[0].cyc < cyc) begin
            n_chk++; n_err++;
            $display("FAIL %s missed cyc=%0d", wq[0].nm, wq[0].cyc);
            void'(wq.pop_front());
        end
        if (wq.size() > 0 && wq[0].cyc == cyc) begin
            exp_t e;
            e = wq.pop_front();
            n_chk++;
            if ((act & e.m) !== (e.w & e.m) || cfg_if.cfg_ready !== e.rdy || sel !== e.sel) begin
                n_err++;
                $display("FAIL %s cyc=%0d got w=%b rdy=%b sel=%0d exp w=%b(mask %b) rdy=%b sel=%0d",
                         e.nm, cyc, act, cfg_if.cfg_ready, sel, e.w, e.m, e.rdy, e.sel);
            end
        end
        while (swq.size() > 0 && swq[0].cyc < cyc) begin
            n_chk++; n_err++;
            $display("FAIL sel_switched missing cyc=%0d exp sel=%0d", swq[0].cyc, swq[0].sel);
            void'(swq.pop_front());
        end
        if (sel_switched !== 1'b0) begin
            n_chk++;
            if (swq.size() == 0) begin
                n_err++;
                $display("FAIL sel_switched unexpected cyc=%0d got %b sel=%0d exp 0",
                         cyc, sel_switched, sel);
            end else begin
                sw_t x;
                x = swq.pop_front();
                if (x.cyc != cyc || sel !== x.sel) begin
                    n_err++;
                    $display("FAIL sel_switched cyc=%0d sel=%0d exp cyc=%0d sel=%0d",
                             cyc, sel, x.cyc, x.sel);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d exp finish before 200000ns", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; period = 16'd4; duty = 16'd1;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_sel = 2'd0;
        run("reset", 1, 1, 3, 1, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 2'd0);
        step_to(2); rst_n = 1'b1;

        // period 4, duty 1
        step_to(3); en = 1'b1;
        run("t1_p4", 4, 4, 7, 4, 16'b0011, 16'b0001, 16'b0001, 1'b1, 1'b1, 1'b1, 2'd0);
        run("t1_p4", 4, 8, 11, 4, 16'b0011, 16'b0001, 16'b0001, 1'b0, 1'b1, 1'b1, 2'd0);

        // period 5 requested mid-stream: takes effect after the current period
        step_to(11); period = 16'd5; duty = 16'd0;
        run("t2_old", 12, 12, 15, 4, 16'b0011, 16'b0001, 16'b0001, 1'b0, 1'b1, 1'b1, 2'd0);
        run("t2_d0", 16, 16, 20, 5, 16'b00011, 16'h0, 16'b00001, 1'b0, 1'b0, 1'b1, 2'd0);
        run("t2_d7", 21, 21, 25, 5, 16'b00011, 16'h1F, 16'b00001, 1'b0, 1'b0, 1'b1, 2'd0);
        step_to(17); duty = 16'd7;

        // period 1 clamps to 2
        step_to(21); period = 16'd1;
        run("t3_p1", 26, 26, 31, 2, 16'b01, 16'b11, 16'b01, 1'b0, 1'b0, 1'b1, 2'd0);

        // select change at cnt=3 lands on the wrap edge
        step_to(30); period = 16'd8; duty = 16'd4;
        run("t4_idle", 32, 32, 34, 8, 16'h0F, 16'h0F, 16'h01, 1'b0, 1'b0, 1'b1, 2'd0);
        run("t4_pend", 32, 35, 38, 8, 16'h0F, 16'h0F, 16'h01, 1'b0, 1'b0, 1'b0, 2'd0);
        run("t4_done", 32, 39, 47, 8, 16'h0F, 16'h0F, 16'h01, 1'b0, 1'b0, 1'b1, 2'd2);
        push_sw(39, 2'd2);
        step_to(34); cfg_if.cfg_valid = 1'b1; cfg_if.cfg_sel = 2'd2;
        step_to(35); cfg_if.cfg_sel = 2'd1;
        step_to(38); cfg_if.cfg_valid = 1'b0;

        // reset, then en=0 handshake and LFSR sequence from the seed
        step_to(47); rst_n = 1'b0; en = 1'b0;
        run("t5_rst", 48, 48, 48, 1, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 2'd0);
        step_to(48); rst_n = 1'b1; period = 16'd2; duty = 16'd1;
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_sel = 2'd3;
        run("t5_pend", 49, 49, 49, 1, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 2'd0);
        run("t5_sw", 50, 50, 50, 1, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 2'd3);
        push_sw(50, 2'd3);
        step_to(49); cfg_if.cfg_valid = 1'b0;
        step_to(50); en = 1'b1;
        run("t5_prn", 51, 51, 52, 2, 16'b01, 16'b01, 16'b01, 1'b1, 1'b1, 1'b1, 2'd3);
        run("t5_prn", 51, 53, 58, 2, 16'b01, 16'b01, 16'b01, 1'b0, 1'b1, 1'b1, 2'd3);

        // reset while a request is pending at cnt=5
        step_to(57); period = 16'd8; duty = 16'd3;
        run("t6_idle", 59, 59, 59, 8, 16'h0F, 16'h07, 16'h01, 1'b0, 1'b0, 1'b1, 2'd3);
        run("t6_pend", 59, 60, 63, 8, 16'h0F, 16'h07, 16'h01, 1'b0, 1'b0, 1'b0, 2'd3);
        step_to(59); cfg_if.cfg_valid = 1'b1; cfg_if.cfg_sel = 2'd1;
        step_to(60); cfg_if.cfg_valid = 1'b0;
        step_to(63); rst_n = 1'b0;
        run("t6_rst", 64, 64, 64, 1, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 2'd0);
        step_to(64); rst_n = 1'b1;
        run("t6_p2", 65, 65, 66, 2, 16'b01, 16'b00, 16'b01, 1'b1, 1'b1, 1'b1, 2'd0);
        run("t6_p8", 67, 67, 74, 8, 16'h0F, 16'h07, 16'h01, 1'b0, 1'b1, 1'b1, 2'd0);

        step_to(76);
        n_chk++;
        if (wq.size() != 0) begin
            n_err++;
            $display("FAIL wave_queue_drain left=%0d exp 0", wq.size());
        end
        n_chk++;
        if (swq.size() != 0) begin
            n_err++;
            $display("FAIL sw_queue_drain left=%0d exp 0", swq.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/dsg_wave_source.md
Name: dsg_wave_source

Overview:
- Upstream stage of the signal generator's 4:1 output mux.
- Generates four candidate 1-bit waveforms from one shared period counter: square, PWM, single-cycle pulse train and pseudo-random bit.
- Drives the mux's 2-bit select.
- Select changes are accepted through a valid/ready handshake and applied only at a period boundary, so the muxed output never carries a truncated period.

Parameters:
- CNT_W, 16, width of the period counter and of the period/duty inputs.
- LFSR_SEED, 16'hACE1, reset and initial value of the 16-bit LFSR; must be non-zero.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  run enable for the waveform generator.
- period  in  CNT_W  period in clk cycles; values 0 and 1 are treated as 2.
- duty  in  CNT_W  PWM high-time in clk cycles.
- cfg_valid  in  1  select-change request valid.
- cfg_sel  in  2  requested select value.
- cfg_ready  out  1  ready to accept a select request.
- wave_sq  out  1  square wave (mux in0).
- wave_pwm  out  1  PWM wave (mux in1).
- wave_pulse  out  1  one-cycle pulse per period (mux in2).
- wave_prn  out  1  pseudo-random bit, one new value per period (mux in3).
- sel  out  2  mux select.
- sel_switched  out  1  one-cycle strobe, high in the cycle sel takes a new value.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - cnt=0; period_l=2; duty_l=0; lfsr=LFSR_SEED.
  - All wave_* outputs 0; sel=0; sel_switched=0; cfg_ready=1.
  - Any pending request is discarded; reset mid-operation behaves identically.
- en=0:
  - cnt held at 0; lfsr held; all wave_* outputs 0.
  - period_l and duty_l reload every cycle (period_l = max(period,2)).
- en=1, counter:
  - cnt counts 0..period_l-1, then wraps to 0.
  - The first cycle with en=1 has cnt=0.
  - period_l and duty_l reload only in the cycle cnt wraps to 0, so inputs changed mid-period take effect at the next period.
- Waveform outputs:
  - Registered; each reflects the cnt value of the previous cycle (latency 1).
  - wave_sq = (cnt < period_l>>1). Odd periods give the shorter high half.
  - wave_pwm = (cnt < duty_l). duty_l=0 gives constant 0; duty_l>=period_l gives constant 1.
  - wave_pulse = (cnt==0).
  - wave_prn = lfsr[0].
- LFSR:
  - Fibonacci, taps 16,14,13,11 (x^16+x^14+x^13+x^11+1), shifts right, feedback into bit 15.
  - Steps once per wrap (cnt==period_l-1 with en=1).
- Select FSM:
  - States IDLE, PEND.
  - IDLE: cfg_ready=1. On cfg_valid&cfg_ready, capture cfg_sel into pend_sel and go to PEND.
  - PEND: cfg_ready=0; cfg_valid ignored.
  - PEND applies pend_sel when either:
    - en=1 and cnt==period_l-1, or
    - en=0, on the next edge.
  - On apply: sel<=pend_sel, sel_switched=1 for that one cycle, FSM returns to IDLE, cfg_ready=1 again in the same cycle sel changes.
  - A request equal to the current sel still completes the handshake and pulses sel_switched.
  - en falling while in PEND applies the request on the next edge.
- Width rules:
  - All compares are unsigned at CNT_W.
  - period_l>>1 truncates.
  - No overflow is possible because cnt < period_l <= 2^CNT_W-1.

Test Plan:
1. Reset, then period=4, duty=1, en=1 from cycle 0 -> cnt 0,1,2,3,0,…; from cycle 1: wave_sq 1,1,0,0 repeating; wave_pwm 1,0,0,0; wave_pulse 1,0,0,0.
2. period=5, duty=0, then duty=7 written mid-period -> wave_sq 1,1,0,0,0; wave_pwm constant 0 until the next wrap, constant 1 afterwards.
3. period=1 -> treated as 2: wave_sq toggles every cycle; wave_pulse 1,0 repeating.
4. period=8, en=1, cfg_valid with cfg_sel=2 at cnt=3 -> cfg_ready low from the next cycle; sel=2 and sel_switched=1 exactly at the wrap edge (cnt 7->0); cfg_ready=1 in the same cycle; a second cfg_valid during PEND is not accepted.
5. en=0, cfg_sel=3 handshake -> sel=3 with sel_switched one edge later. Then en=1, period=2 for 4 periods -> wave_prn follows lfsr[0] from seed ACE1: 1,0,0,0 (LFSR values ACE1, 5670, AB38, 559C).
6. rst_n=0 for one edge while in PEND with cnt=5 -> next cycle: sel=0, cfg_ready=1, all wave_*=0, cnt=0, lfsr=ACE1; the pending request never applies.
